// File: rtl/bram_stream_reader.sv
// Sweeps a contiguous BRAM address range and streams the words out over
// valid/ready with a last marker, covering the RAM's one-cycle read latency.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH:0]   length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  output logic                  read_en_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  last_o,
  input  logic                  ready_i
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

  state_t                state, state_nxt;
  logic                  done_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   rem;
  logic                  vld_p1, last_p1;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]            buf_last;
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            occ;
  logic [1:0]            level;
  logic                  pop, push, issue, issue_last, accept;

  assign pop        = valid_o && ready_i;
  assign push       = vld_p1;
  // Credit: buffered + in flight after this cycle's pop must leave room.
  assign level      = occ + {1'b0, vld_p1} - {1'b0, pop};
  assign issue      = (state == RUN) && (rem != '0) && (level < 2'd2);
  assign issue_last = issue && (rem == REM_ONE);
  assign accept     = (state == IDLE) && start_i && (length_i != '0);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (length_i != '0) state_nxt = RUN;
          else                done_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (issue_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && last_o) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Issue stage: address/count control and the read-in-flight marker
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      done_o  <= 1'b0;
      addr    <= '0;
      rem     <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_o  <= done_nxt;
      vld_p1  <= issue;
      last_p1 <= issue_last;
      if (accept) begin
        addr <= start_addr_i;
        rem  <= length_i;
      end else if (issue) begin
        addr <= addr + ADDR_ONE;
        rem  <= rem - REM_ONE;
      end
    end
  end

  // Capture stage: two-entry output buffer control
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      occ    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_data[wr_ptr] <= rdata_i;
      buf_last[wr_ptr] <= last_p1;
    end
  end

  assign busy_o    = (state != IDLE);
  assign read_en_o = issue;
  assign raddr_o   = addr;
  assign valid_o   = (occ != 2'd0);
  assign data_o    = valid_o ? buf_data[rd_ptr] : '0;
  assign last_o    = valid_o && buf_last[rd_ptr];

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side initiator for the 32x256 block RAM.
- On a start command it sweeps a contiguous address range through the BRAM synchronous read port, and covers the RAM's 1-cycle read latency.
- Data leaves as a valid/ready stream with last marker, backed by a 2-entry output buffer, so downstream consumers (UART TX, DMA, display) can stall freely without losing words.

Parameters:
ADDR_WIDTH, 8, BRAM address width; range length up to 2^ADDR_WIDTH words.
DATA_WIDTH, 32, BRAM / stream word width.

Ports:
clk_i  input  1  system clock; all logic on rising edge.
reset_i  input  1  synchronous, active-high reset.
start_i  input  1  begin a transfer; sampled only in IDLE.
start_addr_i  input  ADDR_WIDTH  first BRAM address.
length_i  input  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH.
busy_o  output  1  high from accepted start until the last word handshakes.
done_o  output  1  one-cycle pulse when a transfer completes.
raddr_o  output  ADDR_WIDTH  to BRAM raddr_i.
read_en_o  output  1  to BRAM read_en_i.
rdata_i  input  DATA_WIDTH  from BRAM rdata_o; valid the cycle after read_en_o.
data_o  output  DATA_WIDTH  stream data (head of buffer).
valid_o  output  1  stream valid.
last_o  output  1  head word is final word of transfer; qualified by valid_o.
ready_i  input  1  stream ready; transfer occurs when valid_o && ready_i.

Behaviour:
- Reset values: busy_o=0, done_o=0, read_en_o=0, raddr_o=0, valid_o=0, last_o=0, data_o=0. Buffer occupancy=0, in-flight flag=0, state=IDLE.
- Reset mid-operation: aborts immediately. The buffer is flushed, no done_o pulse is produced, and the in-flight BRAM read is discarded.

States:
- IDLE:
  - start_i && length_i!=0: latch addr and remaining count, go to RUN, busy_o=1 next cycle.
  - start_i && length_i==0: done_o pulses next cycle, stay IDLE, no read issued.
- RUN:
  - Issue reads while words remain to issue and the credit allows.
  - Go to DRAIN when the final read has been issued.
- DRAIN:
  - Wait until the final word (last_o) handshakes.
  - Then done_o=1 for one cycle, busy_o=0, return to IDLE.
  - The next start_i is accepted from the cycle done_o is high.
- start_i while busy_o=1 is ignored; it is not queued.

Read issue:
- read_en_o=1 with raddr_o=current address when (occupancy + inflight - pop) < 2, where pop = valid_o && ready_i in that cycle.
- inflight is 1 if read_en_o was high the previous cycle.
- Address increments modulo 2^ADDR_WIDTH after each issue. start_addr=0xFE, length=4 reads 0xFE, 0xFF, 0x00, 0x01.
- read_en_o is 0 whenever no read is issued. raddr_o holds its value.

Capture and buffer:
- rdata_i is written into the 2-entry FIFO the cycle after read_en_o was high, with a last flag set for the final issued word.
- Simultaneous push and pop is supported: occupancy is unchanged and order is preserved.
- The credit rule guarantees no overflow; the bench checks for overflow with an assertion.

Latency and throughput:
- start_i at cycle 0 -> read_en_o cycle 1 -> rdata_i cycle 2 -> valid_o cycle 3.
- With ready_i held high: one word per cycle; a length-N transfer completes (last handshake) at cycle N+2, with done_o at cycle N+3.

Backpressure:
- With ready_i low, at most 2 words are buffered and read issue stops.
- data_o, last_o and valid_o are held stable while valid_o && !ready_i.
- Issue resumes in the same cycle ready_i pops.

Length boundaries:
- length_i = 2^ADDR_WIDTH (256) reads every address once, starting at start_addr_i.
- length_i = 1 makes the first word also last.

Test Plan:
1. Basic transfer: preload bram[0x10..0x13] = 0xA0..0xA3; start addr 0x10, len 4, ready_i=1 -> read_en_o cycles 1-4, valid_o cycles 3-6 with data A0, A1, A2, A3; last_o only with A3; done_o cycle 7.
2. Backpressure: same preload, ready_i low cycles 3-10 -> exactly 2 reads issued; data_o=A0 held stable; after release, A0..A3 are delivered in order with no loss or duplication.
3. Wrap and random stall: start 0xFE, len 4, random ready_i -> stream shows contents of 0xFE, 0xFF, 0x00, 0x01; raddr_o wraps; in-flight+buffered never exceeds 2.
4. Edge lengths: len 0 -> done_o pulse next cycle, no read_en_o, no valid_o. Len 1 at addr 0x55 -> single word with last_o=1. Len 256 -> 256 words, all addresses once.
5. Ignored start: start_i pulsed mid-transfer with different address -> no effect; a start on the done_o cycle is accepted.
6. Reset mid-operation: reset_i asserted during a stalled transfer with valid_o=1 and 2 words buffered -> next cycle all outputs at reset values, no done_o; a fresh start then runs cleanly.
